dm_cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between a 32-bit processor port and a 128-bit line-wide main-memory port.
- Serves word reads and writes, fills lines on miss, evicts dirty victims, and flushes all dirty lines on request.
- The main memory is a separate block, connected through a req/Ready handshake.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/dm_cache_controller_if.sv | 30 +++
 rtl/cache_line_store.sv | 58 +++++
 rtl/dm_cache_controller.sv | 172 +++++++++++++++++
 tb/tb_dm_cache_controller.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Geometry is fixed here; the controller and line store both import it.
package cache_pkg;

    localparam int NUM_LINES  = 64;
    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = 4;
    localparam int TAG_W      = 32 - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        FLUSH
    } state_t;

    typedef logic [32*LINE_WORDS-1:0] line_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [TAG_W-1:0]         tag_t;

    function automatic tag_t tag_of(logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic idx_t idx_of(logic [31:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [1:0] word_of(logic [31:0] a);
        return a[3:2];
    endfunction

    function automatic logic [31:0] line_addr(tag_t t, idx_t i);
        return {t, i, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// Line-wide memory port of the cache: fill and write-back requests
// completed by a single Ready_signal pulse.
interface dm_cache_controller_if;

    logic         mem_read_req;
    logic         mem_write_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
    logic         Ready_signal;

    modport master (
        output mem_read_req,
        output mem_write_req,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data,
        input  Ready_signal
    );

    modport slave (
        input  mem_read_req,
        input  mem_write_req,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data,
        output Ready_signal
    );

endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays of the cache with an asynchronous read port,
// a word-write port, a line-fill port and a dirty-clear port.
module cache_line_store
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  idx_t        rd_idx,
    output logic        rd_valid,
    output logic        rd_dirty,
    output tag_t        rd_tag,
    output line_t       rd_line,
    input  logic        wr_en,
    input  idx_t        wr_idx,
    input  logic [1:0]  wr_word,
    input  logic [31:0] wr_data,
    input  logic        fill_en,
    input  idx_t        fill_idx,
    input  tag_t        fill_tag,
    input  line_t       fill_line,
    input  logic        clr_en,
    input  idx_t        clr_idx
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    tag_t                 tags  [NUM_LINES];
    line_t                lines [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = lines[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill_en) begin
                valid[fill_idx] <= 1'b1;
                dirty[fill_idx] <= 1'b0;
            end
            if (wr_en)  dirty[wr_idx]  <= 1'b1;
            if (clr_en) dirty[clr_idx] <= 1'b0;
        end
    end

    // Payload arrays need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_idx]  <= fill_tag;
            lines[fill_idx] <= fill_line;
        end
        if (wr_en) lines[wr_idx][{wr_word, 5'b0} +: 32] <= wr_data;
    end

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller.
// Define CACHE_STATS_EN to add the hit_count/miss_count outputs.
module dm_cache_controller
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic                  c_flush,
    input  logic [31:0]           pr_addr,
    input  logic [31:0]           pr_data,
    output logic [31:0]           data_out,
`ifdef CACHE_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    dm_cache_controller_if.master mem
);

    state_t      state;
    idx_t        idx_q;
    tag_t        tag_q;
    logic [1:0]  word_q;
    logic [31:0] data_q;
    logic        is_wr_q;
    logic        flushing_q;
    logic        refill_q;

    logic        rd_valid;
    logic        rd_dirty;
    tag_t        rd_tag;
    line_t       rd_line;
    logic        hit;
    logic        last_idx;
    logic        wr_en;
    logic        fill_en;
    logic        clr_en;

    cache_line_store u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx_q),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (idx_q),
        .wr_word   (word_q),
        .wr_data   (data_q),
        .fill_en   (fill_en),
        .fill_idx  (idx_q),
        .fill_tag  (tag_q),
        .fill_line (mem.mem_read_data),
        .clr_en    (clr_en),
        .clr_idx   (idx_q)
    );

    assign hit      = rd_valid && (rd_tag == tag_q);
    assign last_idx = (idx_q == idx_t'(NUM_LINES - 1));

    always_comb begin
        wr_en   = (state == COMPARE) && hit && is_wr_q;
        fill_en = (state == ALLOCATE) && mem.Ready_signal;
        clr_en  = (state == WRITE_BACK) && mem.Ready_signal && flushing_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            idx_q              <= '0;
            tag_q              <= '0;
            word_q             <= '0;
            data_q             <= '0;
            is_wr_q            <= 1'b0;
            flushing_q         <= 1'b0;
            refill_q           <= 1'b0;
            data_out           <= '0;
            mem.mem_read_req   <= 1'b0;
            mem.mem_write_req  <= 1'b0;
            mem.mem_addr       <= '0;
            mem.mem_write_data <= '0;
`ifdef CACHE_STATS_EN
            hit_count          <= '0;
            miss_count         <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    refill_q   <= 1'b0;
                    flushing_q <= 1'b0;
                    if (c_flush) begin
                        idx_q <= '0;
                        state <= FLUSH;
                    end else if (write || read) begin
                        idx_q   <= idx_of(pr_addr);
                        tag_q   <= tag_of(pr_addr);
                        word_q  <= word_of(pr_addr);
                        data_q  <= pr_data;
                        is_wr_q <= write;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    refill_q <= 1'b0;
`ifdef CACHE_STATS_EN
                    if (!refill_q) begin
                        if (hit) begin
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end
`endif
                    if (hit) begin
                        if (!is_wr_q) data_out <= rd_line[{word_q, 5'b0} +: 32];
                        state <= IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        mem.mem_write_req  <= 1'b1;
                        mem.mem_addr       <= line_addr(rd_tag, idx_q);
                        mem.mem_write_data <= rd_line;
                        state              <= WRITE_BACK;
                    end else begin
                        mem.mem_read_req <= 1'b1;
                        mem.mem_addr     <= line_addr(tag_q, idx_q);
                        state            <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem.Ready_signal) begin
                        mem.mem_write_req <= 1'b0;
                        if (flushing_q) begin
                            if (last_idx) begin
                                state <= IDLE;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                                state <= FLUSH;
                            end
                        end else begin
                            mem.mem_read_req <= 1'b1;
                            mem.mem_addr     <= line_addr(tag_q, idx_q);
                            state            <= ALLOCATE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (mem.Ready_signal) begin
                        mem.mem_read_req <= 1'b0;
                        refill_q         <= 1'b1;
                        state            <= COMPARE;
                    end
                end
                FLUSH: begin
                    if (rd_valid && rd_dirty) begin
                        flushing_q         <= 1'b1;
                        mem.mem_write_req  <= 1'b1;
                        mem.mem_addr       <= line_addr(rd_tag, idx_q);
                        mem.mem_write_data <= rd_line;
                        state              <= WRITE_BACK;
                    end else if (last_idx) begin
                        state <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller with a line-wide memory model
// that checks each fill and write-back against a queue of expectations.
module tb_dm_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        c_flush = 1'b0;
    logic [31:0] pr_addr = '0;
    logic [31:0] pr_data = '0;
    logic [31:0] data_out;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dm_cache_controller_if mem_if ();

    dm_cache_controller dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .c_flush  (c_flush),
        .pr_addr  (pr_addr),
        .pr_data  (pr_data),
        .data_out (data_out),
`ifdef CACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
    } wb_t;

    int           checks = 0;
    int           failures = 0;
    int           rd_count = 0;
    int           wb_count = 0;
    wb_t          exp_wb [$];
    logic [31:0]  exp_rd [$];
    logic [31:0]  exp_data [$];
    logic [127:0] mem [logic [31:0]];

    function automatic logic [127:0] dflt(logic [31:0] a);
        return {32'hA000_0000 | (a + 32'd12), 32'hA000_0000 | (a + 32'd8),
                32'hA000_0000 | (a + 32'd4),  32'hA000_0000 | a};
    endfunction

    function automatic logic [127:0] line_at(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: Ready pulses on the 3rd sampled cycle of each request.
    initial begin : mem_model
        bit          busy;
        int          cnt;
        logic [31:0] a;
        wb_t         e;
        logic [31:0] ea;
        busy = 1'b0;
        cnt = 0;
        a = '0;
        mem_if.Ready_signal = 1'b0;
        mem_if.mem_read_data = '0;
        forever begin
            @(negedge clk);
            mem_if.Ready_signal = 1'b0;
            if (!rst) begin
                busy = 1'b0;
                continue;
            end
            if (mem_if.mem_read_req || mem_if.mem_write_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    a = mem_if.mem_addr;
                    check("req_exclusive",
                          128'(mem_if.mem_read_req & mem_if.mem_write_req), 128'(0));
                    if (mem_if.mem_write_req) begin
                        wb_count++;
                        check("wb_expected", 128'(exp_wb.size() != 0), 128'(1));
                        if (exp_wb.size() != 0) begin
                            e = exp_wb.pop_front();
                            check("wb_addr", 128'(a), 128'(e.addr));
                            check("wb_line", mem_if.mem_write_data, e.line);
                        end
                        mem[a] = mem_if.mem_write_data;
                    end else begin
                        rd_count++;
                        check("rd_expected", 128'(exp_rd.size() != 0), 128'(1));
                        if (exp_rd.size() != 0) begin
                            ea = exp_rd.pop_front();
                            check("rd_addr", 128'(a), 128'(ea));
                        end
                        mem_if.mem_read_data = line_at(a);
                    end
                end
                cnt++;
                if (cnt == 3) begin
                    mem_if.Ready_signal = 1'b1;
                    busy = 1'b0;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    task automatic op(bit r, bit w, logic [31:0] a, logic [31:0] d);
        read = r;
        write = w;
        pr_addr = a;
        pr_data = d;
        repeat (20) @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic flush();
        c_flush = 1'b1;
        @(negedge clk);
        c_flush = 1'b0;
        repeat (90) @(negedge clk);
    endtask

    initial begin : stim
        int r0;
        int w0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_data_out", 128'(data_out), 128'(0));
        check("rst_rd_req", 128'(mem_if.mem_read_req), 128'(0));
        check("rst_wr_req", 128'(mem_if.mem_write_req), 128'(0));
        check("rst_mem_addr", 128'(mem_if.mem_addr), 128'(0));
        check("rst_wr_data", mem_if.mem_write_data, 128'(0));
`ifdef CACHE_STATS_EN
        check("rst_hits", 128'(hit_count), 128'(0));
        check("rst_misses", 128'(miss_count), 128'(0));
`endif
        rst = 1'b1;
        @(negedge clk);

        // Write miss allocates, then read hits.
        r0 = rd_count; w0 = wb_count;
        exp_rd.push_back(32'h0000_1000);
        op(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        check("s1_fill", 128'(rd_count - r0), 128'(1));
        check("s1_no_wb", 128'(wb_count - w0), 128'(0));
        r0 = rd_count;
        exp_data.push_back(32'hDEAD_BEEF);
        op(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        check("s1_read", 128'(data_out), 128'(exp_data.pop_front()));
        check("s1_read_no_mem", 128'(rd_count - r0), 128'(0));
`ifdef CACHE_STATS_EN
        check("s1_misses", 128'(miss_count), 128'(1));
        check("s1_hits_nz", 128'(hit_count != 0), 128'(1));
`endif

        // Write hit, read back, no memory traffic.
        r0 = rd_count; w0 = wb_count;
        op(1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_BABE);
        exp_data.push_back(32'hCAFE_BABE);
        op(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        check("s2_read", 128'(data_out), 128'(exp_data.pop_front()));
        check("s2_no_rd", 128'(rd_count - r0), 128'(0));
        check("s2_no_wb", 128'(wb_count - w0), 128'(0));

        // Conflict miss evicts the dirty line then fills.
        r0 = rd_count; w0 = wb_count;
        exp_wb.push_back('{32'h0000_1000,
                           {dflt(32'h0000_1000)[127:32], 32'hCAFE_BABE}});
        exp_rd.push_back(32'h0000_2000);
        exp_data.push_back(32'hA000_2000);
        op(1'b1, 1'b0, 32'h0000_2000, 32'h0);
        check("s3_read", 128'(data_out), 128'(exp_data.pop_front()));
        check("s3_wb", 128'(wb_count - w0), 128'(1));
        check("s3_fill", 128'(rd_count - r0), 128'(1));

        // Dirty line at index 1 is the only one a flush writes back.
        exp_rd.push_back(32'h0000_0010);
        op(1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678);
        r0 = rd_count; w0 = wb_count;
        exp_wb.push_back('{32'h0000_0010,
                           {dflt(32'h0000_0010)[127:64], 32'h1234_5678,
                            dflt(32'h0000_0010)[31:0]}});
        flush();
        check("s4_flush_wb", 128'(wb_count - w0), 128'(1));
        check("s4_flush_no_rd", 128'(rd_count - r0), 128'(0));
        w0 = wb_count;
        flush();
        check("s4_flush2_wb", 128'(wb_count - w0), 128'(0));
        check("s4_flush2_no_rd", 128'(rd_count - r0), 128'(0));

        // Reset while a fill is outstanding.
        exp_rd.push_back(32'h0000_3000);
        read = 1'b1;
        pr_addr = 32'h0000_3000;
        n = 0;
        while (!mem_if.mem_read_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("s5_req_seen", 128'(mem_if.mem_read_req), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        read = 1'b0;
        @(negedge clk);
        check("s5_rd_req_drop", 128'(mem_if.mem_read_req), 128'(0));
        check("s5_wr_req_drop", 128'(mem_if.mem_write_req), 128'(0));
        check("s5_data_out", 128'(data_out), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        r0 = rd_count; w0 = wb_count;
        exp_rd.push_back(32'h0000_1000);
        exp_data.push_back(32'hCAFE_BABE);
        op(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        check("s5_read", 128'(data_out), 128'(exp_data.pop_front()));
        check("s5_miss", 128'(rd_count - r0), 128'(1));
        check("s5_no_wb", 128'(wb_count - w0), 128'(0));

        // Read and write together: the write wins.
        r0 = rd_count;
        op(1'b1, 1'b1, 32'h0000_1004, 32'h0BAD_F00D);
        exp_data.push_back(32'h0BAD_F00D);
        op(1'b1, 1'b0, 32'h0000_1004, 32'h0);
        check("s6_write_wins", 128'(data_out), 128'(exp_data.pop_front()));
        check("s6_no_rd", 128'(rd_count - r0), 128'(0));

        check("end_wb_drained", 128'(exp_wb.size()), 128'(0));
        check("end_rd_drained", 128'(exp_rd.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
